// File: rtl/cheri_pkg.sv
// ---------------------------------------------------------------------------
// cheri_pkg
//   Shared CHERI types for the ALU write-back path.
//   - op_cap_t    : capability as produced by the CHERI ALU
//   - wbq_entry_t : one write-back queue slot (valid, exc, rd, ocap)
//   - wbq_ptr_w() : pointer width for a queue of a given depth (min 1 bit)
// ---------------------------------------------------------------------------
package cheri_pkg;

    // Widest register index a queue entry can hold; instances use RD_W <= this.
    localparam int unsigned WBQ_RD_W = 5;

    typedef struct packed {
        logic        tag;
        logic [11:0] perms;
        logic [3:0]  otype;
        logic [31:0] addr;
    } op_cap_t;

    typedef struct packed {
        logic                valid;
        logic                exc;
        logic [WBQ_RD_W-1:0] rd;
        op_cap_t             ocap;
    } wbq_entry_t;

    function automatic int unsigned wbq_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cheri_wbq_fwd.sv
// ---------------------------------------------------------------------------
// cheri_wbq_fwd
//   Youngest-match forwarding lookup for one operand source index.
//   Purely combinational over the registered queue state.
//   Ports:
//     entries  in  queue storage array (DEPTH entries)
//     head_ptr in  index of the oldest entry
//     count    in  number of queued entries
//     rs       in  source register index (0 never hits)
//     hit      out a valid, forwardable entry targets rs
//     ocap     out capability of the youngest such entry, 0 when no hit
// ---------------------------------------------------------------------------
module cheri_wbq_fwd
    import cheri_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned RD_W  = 5
) (
    input  wbq_entry_t       entries [DEPTH],
    input  logic [PTR_W-1:0] head_ptr,
    input  logic [CNT_W-1:0] count,
    input  logic [RD_W-1:0]  rs,
    output logic             hit,
    output op_cap_t          ocap
);

    int unsigned      pos;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        hit  = 1'b0;
        ocap = '0;
        pos  = 0;
        idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            pos = 32'(head_ptr) + k;
            if (pos >= DEPTH) begin
                pos = pos - DEPTH;
            end
            idx = PTR_W'(pos);
            if ((k < 32'(count)) && entries[idx].valid && !entries[idx].exc &&
                (rs != '0) && (entries[idx].rd == WBQ_RD_W'(rs))) begin
                hit  = 1'b1;
                ocap = entries[idx].ocap;
            end
        end
    end

endmodule

// File: rtl/cheri_alu_wb_queue.sv
// ---------------------------------------------------------------------------
// cheri_alu_wb_queue
//   In-order queue between the CHERI ALU result register and the capability
//   register-file write port, with operand forwarding of queued results.
//   Optional feature macro: CHERI_TAGCLR_EXC_EN (tag-clear results retire as
//   exceptions and discard all younger entries).
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     flush_i                 discard all queued entries at the next edge
//     in_valid_i/in_ready_o   ALU result handshake
//     in_rd_i, in_ocap_i      ALU result destination and capability
//     in_tagclr_i             ALU cleared the tag on a violation
//     wb_valid_o/wb_ready_i   write-port handshake for the head entry
//     wb_we_o, wb_rd_o        head performs a write / its destination
//     wb_ocap_o, exc_o        head capability / head retires as exception
//     fwd_rs_i                two operand-stage source indices
//     fwd_hit_o, fwd_ocap_o   per-source forwarding hit and capability
// ---------------------------------------------------------------------------
module cheri_alu_wb_queue
    import cheri_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RD_W  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [RD_W-1:0]      in_rd_i,
    input  op_cap_t              in_ocap_i,
    input  logic                 in_tagclr_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic                 wb_we_o,
    output logic [RD_W-1:0]      wb_rd_o,
    output op_cap_t              wb_ocap_o,
    output logic                 exc_o,
    input  logic [1:0][RD_W-1:0] fwd_rs_i,
    output logic [1:0]           fwd_hit_o,
    output op_cap_t [1:0]        fwd_ocap_o
);

    localparam int unsigned PTR_W = wbq_ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wbq_entry_t       q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    wbq_entry_t head;
    logic       full;
    logic       push;
    logic       pop;
    logic       in_exc;
    logic       exc_pop;
    logic       kill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head = q[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));

    assign wb_valid_o = head.valid;
    assign pop        = head.valid & wb_ready_i;
    assign in_ready_o = ~full | pop;
    assign push       = in_valid_i & in_ready_o;

    // Payloads are not cleared on flush, so qualify them with the head valid.
    assign wb_rd_o   = head.valid ? RD_W'(head.rd) : '0;
    assign wb_ocap_o = head.valid ? head.ocap : '0;
    assign wb_we_o   = head.valid & ~head.exc & (head.rd != '0) & ~flush_i;

`ifdef CHERI_TAGCLR_EXC_EN
    assign in_exc  = in_tagclr_i;
    assign exc_pop = pop & head.exc;
    assign exc_o   = head.valid & head.exc & ~flush_i;
`else
    assign in_exc  = in_tagclr_i & 1'b0;
    assign exc_pop = 1'b0;
    assign exc_o   = 1'b0;
`endif

    // An exception retiring drops every younger entry exactly like a flush.
    assign kill = flush_i | exc_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (kill) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i].valid <= 1'b0;
            end
        end else begin
            // Pop is written first so a same-slot push (full + pop) wins.
            if (pop) begin
                q[rd_ptr].valid <= 1'b0;
                rd_ptr          <= ptr_inc(rd_ptr);
            end
            if (push) begin
                q[wr_ptr] <= '{valid: 1'b1, exc: in_exc,
                               rd: WBQ_RD_W'(in_rd_i), ocap: in_ocap_i};
                wr_ptr    <= ptr_inc(wr_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        cheri_wbq_fwd #(
            .DEPTH(DEPTH),
            .PTR_W(PTR_W),
            .CNT_W(CNT_W),
            .RD_W (RD_W)
        ) u_fwd (
            .entries (q),
            .head_ptr(rd_ptr),
            .count   (count),
            .rs      (fwd_rs_i[i]),
            .hit     (fwd_hit_o[i]),
            .ocap    (fwd_ocap_o[i])
        );
    end

endmodule

// File: tb/tb_cheri_alu_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_cheri_alu_wb_queue
//   Drives a DEPTH=2 and a DEPTH=3 instance from the same stimulus; each has
//   its own expected-result queue checked whenever it retires an entry.
// ---------------------------------------------------------------------------
module tb_cheri_alu_wb_queue;
    import cheri_pkg::*;

    localparam int unsigned RD_W = 5;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic flush_i = 1'b0;
    logic in_valid = 1'b0;
    logic in_tagclr = 1'b0;
    logic wb_ready = 1'b0;
    logic [RD_W-1:0] in_rd = '0;
    op_cap_t in_ocap = '0;
    logic [1:0][RD_W-1:0] fwd_rs = '0;

    logic in_ready [2];
    logic wb_valid [2];
    logic wb_we [2];
    logic exc [2];
    logic [RD_W-1:0] wb_rd [2];
    op_cap_t wb_ocap [2];
    logic [1:0] fwd_hit0, fwd_hit3;
    op_cap_t [1:0] fwd_ocap0, fwd_ocap3;

    typedef struct {
        logic [RD_W-1:0] rd;
        op_cap_t         ocap;
        logic            exc;
    } exp_t;

    exp_t sb [2][$];
    logic [RD_W-1:0] popped [$];
    int depth_of [2] = '{2, 3};
    int pops3 = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cheri_alu_wb_queue #(.DEPTH(2), .RD_W(RD_W)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .in_rd_i(in_rd),
        .in_ocap_i(in_ocap), .in_tagclr_i(in_tagclr),
        .wb_valid_o(wb_valid[0]), .wb_ready_i(wb_ready), .wb_we_o(wb_we[0]),
        .wb_rd_o(wb_rd[0]), .wb_ocap_o(wb_ocap[0]), .exc_o(exc[0]),
        .fwd_rs_i(fwd_rs), .fwd_hit_o(fwd_hit0), .fwd_ocap_o(fwd_ocap0)
    );

    cheri_alu_wb_queue #(.DEPTH(3), .RD_W(RD_W)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .in_rd_i(in_rd),
        .in_ocap_i(in_ocap), .in_tagclr_i(in_tagclr),
        .wb_valid_o(wb_valid[1]), .wb_ready_i(wb_ready), .wb_we_o(wb_we[1]),
        .wb_rd_o(wb_rd[1]), .wb_ocap_o(wb_ocap[1]), .exc_o(exc[1]),
        .fwd_rs_i(fwd_rs), .fwd_hit_o(fwd_hit3), .fwd_ocap_o(fwd_ocap3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_exc(input logic tc);
`ifdef CHERI_TAGCLR_EXC_EN
        return tc;
`else
        return 1'b0 & tc;
`endif
    endfunction

    function automatic op_cap_t rand_cap();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return op_cap_t'(r[48:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [RD_W-1:0] rd, input logic tc, input op_cap_t c);
        in_valid  = 1'b1;
        in_rd     = rd;
        in_tagclr = tc;
        in_ocap   = c;
        tick();
        in_valid  = 1'b0;
        in_tagclr = 1'b0;
    endtask

    task automatic drain();
        wb_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && (sb[0].size() != 0 || sb[1].size() != 0); i++) begin
            tick();
        end
        check("drain_empty", 64'(sb[0].size() + sb[1].size()), 64'(0));
        wb_ready = 1'b0;
    endtask

    // Monitor: sampled mid-cycle, predicts what the coming edge does.
    always @(negedge clk) begin
        exp_t e;
        logic xp;
        if (!rst_i) begin
            for (int d = 0; d < 2; d++) begin
                check("wb_valid", 64'(wb_valid[d]), 64'(sb[d].size() != 0));
                check("in_ready", 64'(in_ready[d]),
                      64'((sb[d].size() < depth_of[d]) || (wb_valid[d] && wb_ready)));
                if (flush_i) begin
                    sb[d].delete();
                end else begin
                    xp = 1'b0;
                    if (wb_valid[d] && wb_ready && sb[d].size() != 0) begin
                        e = sb[d].pop_front();
                        check("wb_rd", 64'(wb_rd[d]), 64'(e.rd));
                        check("wb_ocap", 64'(wb_ocap[d]), 64'(e.ocap));
                        check("wb_we", 64'(wb_we[d]), 64'(!e.exc && e.rd != '0));
                        check("exc_o", 64'(exc[d]), 64'(e.exc));
                        if (d == 0) popped.push_back(e.rd);
                        else pops3++;
                        xp = e.exc;
                    end
                    if (in_valid && in_ready[d]) begin
                        e.rd   = in_rd;
                        e.ocap = in_ocap;
                        e.exc  = exp_exc(in_tagclr);
                        sb[d].push_back(e);
                    end
                    if (xp) sb[d].delete();
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_cap_t cap_a, cap_b, cap_c;
        int pushes, p3_start;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", 64'(wb_valid[0]), 64'(0));
        check("rst_in_ready", 64'(in_ready[0]), 64'(1));
        check("rst_wb_we", 64'(wb_we[0]), 64'(0));
        check("rst_exc", 64'(exc[0]), 64'(0));
        check("rst_wb_rd", 64'(wb_rd[0]), 64'(0));
        check("rst_fwd_hit", 64'(fwd_hit0), 64'(0));
        rst_i = 1'b0;
        tick();

        // Backpressure: full queue accepts a push only alongside a pop
        popped.delete();
        wb_ready = 1'b0;
        push(5'd3, 1'b0, rand_cap());
        push(5'd4, 1'b0, rand_cap());
        check("bp_full_not_ready", 64'(in_ready[0]), 64'(0));
        check("bp_head_rd", 64'(wb_rd[0]), 64'(3));
        in_valid = 1'b1;
        in_rd    = 5'd5;
        in_ocap  = rand_cap();
        wb_ready = 1'b1;
        #1;
        check("bp_ready_with_pop", 64'(in_ready[0]), 64'(1));
        tick();
        in_valid = 1'b0;
        drain();
        check("bp_order_n", 64'(popped.size()), 64'(3));
        check("bp_order0", 64'(popped[0]), 64'(3));
        check("bp_order1", 64'(popped[1]), 64'(4));
        check("bp_order2", 64'(popped[2]), 64'(5));

        // Forwarding: youngest of two same-rd entries wins (across wrap)
        cap_a = rand_cap();
        cap_b = rand_cap();
        while (cap_b == cap_a) cap_b = rand_cap();
        push(5'd7, 1'b0, cap_a);
        push(5'd7, 1'b0, cap_b);
        fwd_rs[0] = 5'd7;
        fwd_rs[1] = 5'd0;
        #1;
        check("fwd_hit_01", 64'(fwd_hit0), 64'(2'b01));
        check("fwd_ocap_young", 64'(fwd_ocap0[0]), 64'(cap_b));
        check("fwd_ocap_nohit", 64'(fwd_ocap0[1]), 64'(0));
        fwd_rs[1] = 5'd7;
        #1;
        check("fwd_hit_11", 64'(fwd_hit0), 64'(2'b11));
        drain();
        fwd_rs = '0;
        push(5'd0, 1'b0, rand_cap());
        #1;
        check("fwd_rd0_nohit", 64'(fwd_hit0), 64'(0));
        cap_c = rand_cap();
        in_valid  = 1'b1;
        in_rd     = 5'd9;
        in_ocap   = cap_c;
        fwd_rs[0] = 5'd9;
        #1;
        check("fwd_same_cycle_invisible", 64'(fwd_hit0[0]), 64'(0));
        tick();
        in_valid = 1'b0;
        #1;
        check("fwd_after_push_hit", 64'(fwd_hit0[0]), 64'(1));
        check("fwd_after_push_ocap", 64'(fwd_ocap0[0]), 64'(cap_c));
        fwd_rs = '0;
        drain();

        // Flush overrides simultaneous push and pop
        push(5'd1, 1'b0, rand_cap());
        push(5'd2, 1'b0, rand_cap());
        in_valid = 1'b1;
        in_rd    = 5'd11;
        in_ocap  = rand_cap();
        wb_ready = 1'b1;
        flush_i  = 1'b1;
        #1;
        check("flush_no_write", 64'(wb_we[0]), 64'(0));
        check("flush_no_exc", 64'(exc[0]), 64'(0));
        tick();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        wb_ready = 1'b0;
        fwd_rs[0] = 5'd11;
        fwd_rs[1] = 5'd1;
        #1;
        check("flush_empty2", 64'(wb_valid[0]), 64'(0));
        check("flush_empty3", 64'(wb_valid[1]), 64'(0));
        check("flush_we", 64'(wb_we[0]), 64'(0));
        check("flush_fwd", 64'(fwd_hit0), 64'(0));

        // Asynchronous reset mid-stream
        push(5'd12, 1'b0, rand_cap());
        push(5'd13, 1'b0, rand_cap());
        fwd_rs[0] = 5'd12;
        fwd_rs[1] = 5'd13;
        #1;
        check("pre_rst_fwd", 64'(fwd_hit0), 64'(2'b11));
        #1;
        rst_i = 1'b1;
        sb[0].delete();
        sb[1].delete();
        #1;
        check("async_rst_wb_valid", 64'(wb_valid[0]), 64'(0));
        check("async_rst_in_ready", 64'(in_ready[0]), 64'(1));
        check("async_rst_fwd", 64'(fwd_hit0), 64'(0));
        @(posedge clk);
        #1;
        rst_i  = 1'b0;
        fwd_rs = '0;
        tick();

        // Wraparound at varying push/pop rates; DEPTH=3 instance tracks 10 pushes
        p3_start = pops3;
        pushes = 0;
        for (int cyc = 0; cyc < 200 && pushes < 10; cyc++) begin
            wb_ready = ($urandom_range(0, 2) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_rd    = RD_W'($urandom_range(1, 31));
            in_ocap  = rand_cap();
            #1;
            if (in_valid && in_ready[1]) pushes++;
            tick();
        end
        in_valid = 1'b0;
        check("wrap_pushes", 64'(pushes), 64'(10));
        drain();
        check("wrap_pops3", 64'(pops3 - p3_start), 64'(10));

        // Tag-clear result at the head
        popped.delete();
        push(5'd2, 1'b1, rand_cap());
        push(5'd6, 1'b0, rand_cap());
        fwd_rs[0] = 5'd2;
        fwd_rs[1] = 5'd6;
        #1;
`ifdef CHERI_TAGCLR_EXC_EN
        check("tc_exc", 64'(exc[0]), 64'(1));
        check("tc_we", 64'(wb_we[0]), 64'(0));
        check("tc_fwd", 64'(fwd_hit0), 64'(2'b10));
`else
        check("tc_exc", 64'(exc[0]), 64'(0));
        check("tc_we", 64'(wb_we[0]), 64'(1));
        check("tc_fwd", 64'(fwd_hit0), 64'(2'b11));
`endif
        wb_ready = 1'b1;
        tick();
`ifdef CHERI_TAGCLR_EXC_EN
        check("tc_after_valid", 64'(wb_valid[0]), 64'(0));
`else
        check("tc_after_valid", 64'(wb_valid[0]), 64'(1));
`endif
        drain();
        fwd_rs = '0;
`ifdef CHERI_TAGCLR_EXC_EN
        check("tc_pop_n", 64'(popped.size()), 64'(1));
`else
        check("tc_pop_n", 64'(popped.size()), 64'(2));
        check("tc_pop1", 64'(popped[1]), 64'(6));
`endif
        check("tc_pop0", 64'(popped[0]), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
